acc_send: RTL and testbench

ACC_SEND -- requirements
Module: acc_send

---
 rtl/acc_mpi_pkg.sv | 39 +++
 rtl/send_pkt_fmt.sv | 31 +++
 rtl/acc_send.sv | 219 +++++++++++++++++++++
 tb/tb_acc_send.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_mpi_pkg.sv
// ============================================================================
// acc_mpi_pkg : shared packet layout, opcodes, result codes and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package acc_mpi_pkg;

  localparam logic [4:0]  c_pkt_type_eager  = 5'b10000;
  localparam logic [4:0]  c_pkt_type_long   = 5'b10001;

  localparam int          c_pkt_type_lsb    = 123;
  localparam int          c_pkt_rank_lsb    = 96;
  localparam int          c_pkt_tag_lsb     = 88;
  localparam int          c_pkt_payload_lsb = 56;
  localparam int          c_pkt_index_lsb   = 0;

  localparam int          c_index_w         = 11;
  localparam int          c_addr_w          = 20;

  localparam logic [2:0]  c_op_eager        = 3'b001;
  localparam logic [2:0]  c_op_long         = 3'b010;
  localparam logic [2:0]  c_op_status       = 3'b100;

  localparam logic [31:0] c_res_ok          = 32'h52052020;
  localparam logic [31:0] c_res_err         = 32'hdeaddead;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_PUSH    = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/send_pkt_fmt.sv
// ============================================================================
// send_pkt_fmt : combinational packet builder (type, rank, tag, payload, index)
// Rev 1.0
// ============================================================================
`default_nettype none

module send_pkt_fmt
  import acc_mpi_pkg::*;
#(
  parameter int PKT_W = 128
) (
  input  logic [4:0]           i_type,
  input  logic [7:0]           i_rank,
  input  logic [7:0]           i_tag,
  input  logic [31:0]          i_payload,
  input  logic [c_index_w-1:0] i_index,
  output logic [PKT_W-1:0]     o_pkt
);

  always_comb begin
    o_pkt = '0;
    o_pkt[c_pkt_type_lsb    +: 5]         = i_type;
    o_pkt[c_pkt_rank_lsb    +: 8]         = i_rank;
    o_pkt[c_pkt_tag_lsb     +: 8]         = i_tag;
    o_pkt[c_pkt_payload_lsb +: 32]        = i_payload;
    o_pkt[c_pkt_index_lsb   +: c_index_w] = i_index;
  end

endmodule

`default_nettype wire

// File: rtl/acc_send.sv
// ============================================================================
// acc_send : MPI send engine -- eager and long (memory-fetched) packet pusher
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_send
  import acc_mpi_pkg::*;
#(
  parameter int packetizer_width = 128,
  parameter int TIMEOUT          = 100000000
) (
  input  logic                        nios_clk,
  input  logic                        reset_n,
  input  logic                        clk_en,
  input  logic [31:0]                 data_in_a,
  input  logic [31:0]                 data_in_b,
  input  logic [2:0]                  in_opcode,
  input  logic                        start,
  output logic [31:0]                 result,
  output logic                        done,
  output logic                        read,
  output logic [c_addr_w-1:0]         read_addr,
  input  logic [31:0]                 readdata,
  input  logic                        readdatavalid,
  output logic                        write_fifo,
  input  logic                        fifo_full,
  output logic [packetizer_width-1:0] packet_out
);

  localparam logic [31:0] c_timeout = 32'(TIMEOUT);

  logic                        r_rst_meta;
  logic                        r_rst_n;
  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [2:0]                  r_op;
  logic [7:0]                  r_rank;
  logic [7:0]                  r_tag;
  logic [31:0]                 r_b;
  logic [c_index_w-1:0]        r_index;
  logic [c_index_w-1:0]        w_index_nxt;
  logic [31:0]                 r_timer;
  logic [31:0]                 r_sent;
  logic [31:0]                 r_result;
  logic [31:0]                 w_result_nxt;
  logic                        r_done;
  logic                        w_done_nxt;
  logic [packetizer_width-1:0] r_pkt;
  logic [packetizer_width-1:0] w_pkt;
  logic                        w_capture;
  logic                        w_load_pkt;
  logic [4:0]                  w_fmt_type;
  logic [31:0]                 w_fmt_payload;
  logic [c_index_w-1:0]        w_fmt_index;
  logic [c_index_w-1:0]        w_count;
  logic [c_addr_w-1:0]         w_base;
  logic                        w_push;
  logic                        w_timeout;
  logic                        w_last;
  logic                        w_unused_a;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge nios_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  assign w_count    = r_b[c_index_w-1:0];
  assign w_base     = r_b[c_index_w +: c_addr_w];
  assign w_push     = clk_en && (r_state == ST_PUSH) && !fifo_full;
  assign w_timeout  = (r_timer >= c_timeout);
  assign w_last     = (r_op == c_op_eager) || (r_index == (w_count - 11'd1));
  assign w_unused_a = ^{data_in_a[31:24], data_in_a[7:0]};

  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_result_nxt  = r_result;
    w_done_nxt    = 1'b0;
    w_capture     = 1'b0;
    w_load_pkt    = 1'b0;
    w_fmt_type    = c_pkt_type_eager;
    w_fmt_payload = r_b;
    w_fmt_index   = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_op == c_op_status) begin
          w_result_nxt = r_sent;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_FIN;
        end else if (r_op == c_op_eager) begin
          w_load_pkt  = 1'b1;
          w_state_nxt = ST_PUSH;
        end else if ((r_op == c_op_long) && (w_count != '0)) begin
          w_index_nxt = '0;
          w_state_nxt = ST_RD_REQ;
        end else begin
          w_result_nxt = c_res_err;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_FIN;
        end
      end
      ST_RD_REQ: begin
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (readdatavalid) begin
          w_fmt_type    = c_pkt_type_long;
          w_fmt_payload = readdata;
          w_fmt_index   = r_index;
          w_load_pkt    = 1'b1;
          w_state_nxt   = ST_PUSH;
        end else if (w_timeout) begin
          w_result_nxt = c_res_err;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_FIN;
        end
      end
      ST_PUSH: begin
        if (!fifo_full) begin
          if (w_last) begin
            w_result_nxt = c_res_ok;
            w_done_nxt   = 1'b1;
            w_state_nxt  = ST_FIN;
          end else begin
            w_index_nxt = r_index + 11'd1;
            w_state_nxt = ST_RD_REQ;
          end
        end else if (w_timeout) begin
          w_result_nxt = c_res_err;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  send_pkt_fmt #(
    .PKT_W     (packetizer_width)
  ) u_fmt (
    .i_type    (w_fmt_type),
    .i_rank    (r_rank),
    .i_tag     (r_tag),
    .i_payload (w_fmt_payload),
    .i_index   (w_fmt_index),
    .o_pkt     (w_pkt)
  );

  always_ff @(posedge nios_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_rank   <= '0;
      r_tag    <= '0;
      r_b      <= '0;
      r_index  <= '0;
      r_timer  <= '0;
      r_sent   <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_pkt    <= '0;
    end else begin
      // done stays a single-cycle pulse even if clk_en drops in FIN
      r_done <= clk_en && w_done_nxt;
      if (clk_en) begin
        r_state  <= w_state_nxt;
        r_index  <= w_index_nxt;
        r_result <= w_result_nxt;
        if (w_capture) begin
          r_op   <= in_opcode;
          r_rank <= data_in_a[23:16];
          r_tag  <= data_in_a[15:8];
          r_b    <= data_in_b;
        end
        if (w_load_pkt) begin
          r_pkt <= w_pkt;
        end
        if (w_push) begin
          r_sent <= r_sent + 32'd1;
        end
        if (w_state_nxt != r_state) begin
          r_timer <= '0;
        end else if ((r_state == ST_PUSH) || (r_state == ST_RD_WAIT)) begin
          r_timer <= r_timer + 32'd1;
        end else begin
          r_timer <= '0;
        end
      end
    end
  end

  assign result     = r_result;
  assign done       = r_done;
  assign read       = clk_en && (r_state == ST_RD_REQ);
  assign read_addr  = w_base + c_addr_w'(r_index);
  assign write_fifo = w_push;
  assign packet_out = r_pkt;

endmodule

`default_nettype wire

// File: tb/tb_acc_send.sv
// ============================================================================
// tb_acc_send : directed self-checking bench for acc_send
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acc_send;

  logic         nios_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clk_en = 1'b1;
  logic [31:0]  data_in_a = '0;
  logic [31:0]  data_in_b = '0;
  logic [2:0]   in_opcode = '0;
  logic         start = 1'b0;
  logic [31:0]  result;
  logic         done;
  logic         read;
  logic [19:0]  read_addr;
  logic [31:0]  readdata = '0;
  logic         readdatavalid = 1'b0;
  logic         write_fifo;
  logic         fifo_full = 1'b0;
  logic [127:0] packet_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pushes = 0;
  int model_sent = 0;
  logic [127:0] last_pkt = '0;

  // Model state: what the DUT must still emit, in order.
  logic [127:0] exp_pkts[$];
  logic [31:0]  exp_results[$];
  logic [19:0]  exp_reads[$];

  typedef struct packed {
    int          due;
    logic [31:0] data;
  } mem_t;
  mem_t pend[$];

  acc_send #(
    .packetizer_width (128),
    .TIMEOUT          (16)
  ) dut (
    .nios_clk      (nios_clk),
    .reset_n       (reset_n),
    .clk_en        (clk_en),
    .data_in_a     (data_in_a),
    .data_in_b     (data_in_b),
    .in_opcode     (in_opcode),
    .start         (start),
    .result        (result),
    .done          (done),
    .read          (read),
    .read_addr     (read_addr),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .write_fifo    (write_fifo),
    .fifo_full     (fifo_full),
    .packet_out    (packet_out)
  );

  always #5 nios_clk = ~nios_clk;
  always @(posedge nios_clk) cyc <= cyc + 1;

  function automatic logic [127:0] mk_pkt(input logic [4:0] typ, input logic [7:0] rank,
                                          input logic [7:0] tag, input logic [31:0] payload,
                                          input logic [10:0] idx);
    return {typ, 19'd0, rank, tag, payload, 45'd0, idx};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: every read returns address+1 two cycles later.
  always @(negedge nios_clk) begin
    if (read) pend.push_back('{due: cyc + 2, data: {12'd0, read_addr} + 32'd1});
    readdatavalid = 1'b0;
    readdata      = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      readdatavalid = 1'b1;
      readdata      = pend[0].data;
      void'(pend.pop_front());
    end
  end

  // Compare process: every read, push and done is matched against the model.
  always @(negedge nios_clk) begin
    if (reset_n) begin
      if (write_fifo) begin
        pushes++;
        last_pkt = packet_out;
        chk("push_while_full", 128'(fifo_full), 128'd0);
        if (exp_pkts.size() == 0) chk("push_unexpected", packet_out, 128'd0 - 128'd1);
        else chk("push_packet", packet_out, exp_pkts.pop_front());
      end
      if (read) begin
        if (exp_reads.size() == 0) chk("read_unexpected", 128'(read_addr), 128'd0 - 128'd1);
        else chk("read_addr", 128'(read_addr), 128'(exp_reads.pop_front()));
      end
      if (done) begin
        if (exp_results.size() == 0) chk("done_unexpected", 128'(result), 128'd0 - 128'd1);
        else chk("done_result", 128'(result), 128'(exp_results.pop_front()));
      end
    end
  end

  task automatic tick_to(input int k);
    while (cyc < k) begin
      @(posedge nios_clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] rank, input logic [7:0] tag,
                       input logic [31:0] b, output int t);
    @(posedge nios_clk);
    #1;
    t         = cyc;
    start     = 1'b1;
    in_opcode = op;
    data_in_a = {8'hA5, rank, tag, 8'h5A};
    data_in_b = b;
    @(posedge nios_clk);
    #1;
    start     = 1'b0;
    in_opcode = 3'b000;
    data_in_a = '0;
    data_in_b = '0;
  endtask

  task automatic wait_done(input int limit, output int at, output logic [31:0] res);
    at  = -1;
    res = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge nios_clk);
      if (done) begin
        at  = cyc;
        res = result;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL done_wait: no done within %0d cycles, required one", limit);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_result"},     128'(result),     128'd0);
    chk({name, "_done"},       128'(done),       128'd0);
    chk({name, "_read"},       128'(read),       128'd0);
    chk({name, "_read_addr"},  128'(read_addr),  128'd0);
    chk({name, "_write_fifo"}, 128'(write_fifo), 128'd0);
    chk({name, "_packet_out"}, packet_out,       128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int at;
    int p0;
    logic [31:0] res;
    logic [127:0] held;
    bit found;

    // Reset state
    repeat (3) @(posedge nios_clk);
    @(negedge nios_clk);
    chk_all_zero("reset");
    @(posedge nios_clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge nios_clk);
    #1;

    // STATUS on a fresh block reports zero
    exp_results.push_back(32'(model_sent));
    issue(3'b100, 8'd0, 8'd0, 32'd0, t);
    wait_done(20, at, res);
    chk("status_fresh", 128'(res), 128'd0);
    chk("status_latency", 128'(at), 128'(t + 2));

    // EAGER rank 3 tag 7 payload 0x1234
    exp_pkts.push_back(mk_pkt(5'b10000, 8'd3, 8'd7, 32'h1234, 11'd0));
    exp_results.push_back(32'h52052020);
    model_sent++;
    issue(3'b001, 8'd3, 8'd7, 32'h1234, t);
    tick_to(t + 2);
    @(negedge nios_clk);
    chk("eager_write_T+2", 128'(write_fifo), 128'd1);
    chk("eager_pkt_literal", packet_out, 128'h80000003_07000012_34000000_00000000);
    chk("eager_rank_tag", 128'(packet_out[103:88]), 128'h0307);
    wait_done(20, at, res);
    chk("eager_done_T+3", 128'(at), 128'(t + 3));
    chk("eager_result", 128'(res), 128'h52052020);

    // LONG N=4 base 0x100, with a stray start that must be ignored
    for (int i = 0; i < 4; i++) begin
      exp_reads.push_back(20'h00100 + 20'(i));
      exp_pkts.push_back(mk_pkt(5'b10001, 8'd5, 8'd9, 32'h101 + 32'(i), 11'(i)));
    end
    exp_results.push_back(32'h52052020);
    model_sent += 4;
    p0 = pushes;
    issue(3'b010, 8'd5, 8'd9, {1'b0, 20'h00100, 11'd4}, t);
    tick_to(t + 4);
    start = 1'b1; in_opcode = 3'b001; data_in_b = 32'hBAD0BAD0;
    @(posedge nios_clk);
    #1 start = 1'b0; in_opcode = 3'b000; data_in_b = '0;
    wait_done(200, at, res);
    chk("long_result", 128'(res), 128'h52052020);
    chk("long_push_count", 128'(pushes - p0), 128'd4);
    chk("long_last_pkt", last_pkt, 128'h88000005_09000001_04000000_00000003);

    // clk_en low for three cycles right after start delays everything by three
    exp_pkts.push_back(mk_pkt(5'b10000, 8'h11, 8'h22, 32'hCAFEF00D, 11'd0));
    exp_results.push_back(32'h52052020);
    model_sent++;
    issue(3'b001, 8'h11, 8'h22, 32'hCAFEF00D, t);
    clk_en = 1'b0;
    tick_to(t + 4);
    clk_en = 1'b1;
    wait_done(20, at, res);
    chk("clken_done_T+6", 128'(at), 128'(t + 6));

    // fifo_full for five PUSH cycles: packet stable, exactly one push on release
    exp_pkts.push_back(mk_pkt(5'b10000, 8'd1, 8'd2, 32'hABCD, 11'd0));
    exp_results.push_back(32'h52052020);
    model_sent++;
    fifo_full = 1'b1;
    p0 = pushes;
    issue(3'b001, 8'd1, 8'd2, 32'hABCD, t);
    tick_to(t + 2);
    @(negedge nios_clk);
    held = packet_out;
    chk("stall_pkt", held, mk_pkt(5'b10000, 8'd1, 8'd2, 32'hABCD, 11'd0));
    for (int k = 3; k <= 6; k++) begin
      tick_to(t + k);
      @(negedge nios_clk);
      chk("stall_pkt_stable", packet_out, held);
      chk("stall_no_write", 128'(write_fifo), 128'd0);
    end
    tick_to(t + 7);
    fifo_full = 1'b0;
    wait_done(20, at, res);
    chk("stall_done_T+8", 128'(at), 128'(t + 8));
    chk("stall_push_count", 128'(pushes - p0), 128'd1);

    // Illegal commands
    exp_results.push_back(32'hdeaddead);
    issue(3'b010, 8'd1, 8'd1, {1'b0, 20'h00200, 11'd0}, t);
    wait_done(20, at, res);
    chk("long_n0_result", 128'(res), 128'hdeaddead);
    chk("long_n0_latency", 128'(at), 128'(t + 2));
    exp_results.push_back(32'hdeaddead);
    issue(3'b111, 8'd1, 8'd1, 32'h77, t);
    wait_done(20, at, res);
    chk("op111_result", 128'(res), 128'hdeaddead);
    exp_results.push_back(32'hdeaddead);
    issue(3'b000, 8'd1, 8'd1, 32'h77, t);
    wait_done(20, at, res);
    chk("op000_result", 128'(res), 128'hdeaddead);

    // Timeout with fifo_full stuck, then STATUS
    exp_results.push_back(32'hdeaddead);
    fifo_full = 1'b1;
    issue(3'b001, 8'd4, 8'd4, 32'h44, t);
    wait_done(60, at, res);
    chk("timeout_result", 128'(res), 128'hdeaddead);
    chk("timeout_done_T+19", 128'(at), 128'(t + 19));
    @(posedge nios_clk);
    #1 fifo_full = 1'b0;
    exp_results.push_back(32'(model_sent));
    issue(3'b100, 8'd0, 8'd0, 32'd0, t);
    wait_done(20, at, res);
    chk("status_after_timeout", 128'(res), 128'd7);

    // Reset during LONG index 2
    for (int i = 0; i < 4; i++) begin
      exp_reads.push_back(20'h00300 + 20'(i));
      exp_pkts.push_back(mk_pkt(5'b10001, 8'd6, 8'd6, 32'h301 + 32'(i), 11'(i)));
    end
    exp_results.push_back(32'h52052020);
    p0 = pushes;
    issue(3'b010, 8'd6, 8'd6, {1'b0, 20'h00300, 11'd4}, t);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge nios_clk);
      if (read && read_addr == 20'h00302) begin
        found = 1'b1;
        break;
      end
    end
    chk("reset_reached_index2", 128'(found), 128'd1);
    chk("reset_pushes_before", 128'(pushes - p0), 128'd2);
    @(posedge nios_clk);
    #1;
    reset_n = 1'b0;
    exp_pkts.delete();
    exp_reads.delete();
    exp_results.delete();
    pend.delete();
    model_sent = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge nios_clk);
      chk_all_zero("in_reset");
    end
    @(posedge nios_clk);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge nios_clk);
    #1;
    exp_pkts.push_back(mk_pkt(5'b10000, 8'd8, 8'd1, 32'h55, 11'd0));
    exp_results.push_back(32'h52052020);
    model_sent++;
    issue(3'b001, 8'd8, 8'd1, 32'h55, t);
    wait_done(20, at, res);
    chk("post_reset_eager_T+3", 128'(at), 128'(t + 3));
    chk("post_reset_eager_result", 128'(res), 128'h52052020);
    exp_results.push_back(32'(model_sent));
    issue(3'b100, 8'd0, 8'd0, 32'd0, t);
    wait_done(20, at, res);
    chk("status_after_reset", 128'(res), 128'd1);

    repeat (5) @(posedge nios_clk);
    @(negedge nios_clk);
    chk("pkts_outstanding", 128'(exp_pkts.size()), 128'd0);
    chk("reads_outstanding", 128'(exp_reads.size()), 128'd0);
    chk("results_outstanding", 128'(exp_results.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
